// File: rtl/wb_dsp_equation_fetch.sv
// wb_dsp_equation_fetch: Wishbone classic-read descriptor fetch engine.
// Round-robin arbitrates per-channel start requests, reads a DESC_WORDS
// descriptor one single read per beat, presents it on valid/ready and can
// follow the descriptor next-pointer chain. Handles rty/err/stop and a chain
// length cap. Defining WB_DSP_EQ_FETCH_TIMEOUT_EN adds a WAIT watchdog.
module wb_dsp_equation_fetch #(
  parameter int dw             = 32,
  parameter int aw             = 32,
  parameter int NUM_CH         = 4,
  parameter int DESC_WORDS     = 3,
  parameter int NEXT_IDX       = 2,
  parameter int MAX_RETRY      = 3,
  parameter int MAX_CHAIN      = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     wb_clk,
  input  logic                     wb_rst_n,
  output logic [aw-1:0]            wb_adr_o,
  output logic [dw-1:0]            wb_dat_o,
  output logic [3:0]               wb_sel_o,
  output logic                     wb_we_o,
  output logic                     wb_cyc_o,
  output logic                     wb_stb_o,
  output logic [2:0]               wb_cti_o,
  output logic [1:0]               wb_bte_o,
  input  logic [dw-1:0]            wb_dat_i,
  input  logic                     wb_ack_i,
  input  logic                     wb_err_i,
  input  logic                     wb_rty_i,
  input  logic [NUM_CH-1:0]        begin_equation,
  input  logic [NUM_CH*aw-1:0]     equation_base,
  input  logic [dw-1:0]            control_reg,
  output logic [dw-1:0]            status_reg,
  output logic                     desc_valid,
  input  logic                     desc_ready,
  output logic [2:0]               desc_channel,
  output logic [DESC_WORDS*dw-1:0] desc_data
);
  localparam int WW = $clog2(DESC_WORDS);
  localparam int CW = $clog2(MAX_CHAIN + 1);
  localparam int RW = $clog2(MAX_RETRY + 1);
  // sticky bit positions, mapped to status_reg[4:1]
  localparam int B_BUS = 0, B_ABT = 1, B_OVF = 2, B_TMO = 3;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_PRESENT, S_ERROR} state_e;

  state_e                          state_q, state_d;
  logic [aw-1:0]                   base_q, base_d;
  logic [WW-1:0]                   word_q, word_d;
  logic [CW-1:0]                   chain_q, chain_d;
  logic [RW-1:0]                   rtry_q, rtry_d;
  logic [DESC_WORDS-1:0][dw-1:0]   data_q, data_d;
  logic [2:0]                      ch_q, ch_d, lg_q, lg_d;
  logic                            stop_q, stop_d;
  logic [NUM_CH-1:0]               pending_q, pending_d, pend_clr;
  logic [3:0]                      sticky_q, sticky_d, sset;
  logic [NUM_CH-1:0]               gnt_oh;
  logic [2:0]                      gnt_ch;
  logic [aw-1:0]                   gnt_base;
  logic                            gnt_found, stop_any, tmo_hit;
  logic [aw-1:0]                   next_ptr;

  assign stop_any = stop_q | control_reg[8];
  assign next_ptr = aw'(data_q[NEXT_IDX]);

`ifdef WB_DSP_EQ_FETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  assign tmo_hit = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  // watchdog counts consecutive WAIT cycles of one beat
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) tmo_q <= '0;
    else           tmo_q <= (state_q == S_WAIT && state_d == S_WAIT) ? tmo_q + TW'(1) : '0;
  end
`else
  localparam int unused_tmo_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  // round-robin pick starting one past the last grant
  always_comb begin
    gnt_oh    = '0;
    gnt_ch    = '0;
    gnt_found = 1'b0;
    gnt_base  = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!gnt_found && pending_q[(int'(lg_q) + k) % NUM_CH]) begin
        gnt_found = 1'b1;
        gnt_oh[(int'(lg_q) + k) % NUM_CH] = 1'b1;
        gnt_ch = 3'((int'(lg_q) + k) % NUM_CH);
      end
    end
    for (int i = 0; i < NUM_CH; i++)
      if (gnt_oh[i]) gnt_base = equation_base[i*aw +: aw];
  end

  // fetch FSM next state and datapath updates
  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    word_d   = word_q;
    chain_d  = chain_q;
    rtry_d   = rtry_q;
    data_d   = data_q;
    ch_d     = ch_q;
    lg_d     = lg_q;
    stop_d   = stop_q;
    pend_clr = '0;
    sset     = '0;
    case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (gnt_found) begin
          pend_clr = gnt_oh;
          lg_d     = gnt_ch;
          ch_d     = gnt_ch;
          base_d   = gnt_base;
          word_d   = '0;
          chain_d  = CW'(1);
          rtry_d   = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        stop_d  = stop_any;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        stop_d = stop_any;
        if (wb_err_i) begin
          sset[B_BUS] = 1'b1;
          sset[B_ABT] = stop_any;
          state_d     = S_ERROR;
        end else if (wb_ack_i) begin
          data_d[word_q] = wb_dat_i;
          rtry_d         = '0;
          if (stop_any) begin
            sset[B_ABT] = 1'b1;
            state_d     = S_IDLE;
          end else if (word_q == WW'(DESC_WORDS - 1)) begin
            state_d = S_PRESENT;
          end else begin
            word_d  = word_q + WW'(1);
            state_d = S_FETCH;
          end
        end else if (wb_rty_i) begin
          if (stop_any) begin
            sset[B_ABT] = 1'b1;
            state_d     = S_IDLE;
          end else if (rtry_q >= RW'(MAX_RETRY)) begin
            sset[B_BUS] = 1'b1;
            state_d     = S_ERROR;
          end else begin
            rtry_d  = rtry_q + RW'(1);
            state_d = S_FETCH;
          end
        end else if (tmo_hit) begin
          sset[B_TMO] = 1'b1;
          state_d     = S_ERROR;
        end
      end
      S_PRESENT: begin
        stop_d = stop_any;
        if (desc_ready) begin
          state_d = S_IDLE;
          if (control_reg[9] && next_ptr != '0 && !stop_any) begin
            if (chain_q < CW'(MAX_CHAIN)) begin
              base_d  = next_ptr;
              word_d  = '0;
              rtry_d  = '0;
              chain_d = chain_q + CW'(1);
              state_d = S_FETCH;
            end else begin
              sset[B_OVF] = 1'b1;
            end
          end
        end
      end
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // set wins over clear for both pending and sticky status
  assign pending_d = (pending_q & ~pend_clr) | begin_equation | control_reg[NUM_CH-1:0];
  assign sticky_d  = (sticky_q & ~{4{control_reg[10]}}) | sset;

  // state and datapath registers
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      word_q    <= '0;
      chain_q   <= '0;
      rtry_q    <= '0;
      data_q    <= '0;
      ch_q      <= '0;
      lg_q      <= 3'(NUM_CH - 1);
      stop_q    <= 1'b0;
      pending_q <= '0;
      sticky_q  <= '0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      word_q    <= word_d;
      chain_q   <= chain_d;
      rtry_q    <= rtry_d;
      data_q    <= data_d;
      ch_q      <= ch_d;
      lg_q      <= lg_d;
      stop_q    <= stop_d;
      pending_q <= pending_d;
      sticky_q  <= sticky_d;
    end
  end

  // bus is driven only while a beat is outstanding
  assign wb_cyc_o     = (state_q == S_WAIT);
  assign wb_stb_o     = wb_cyc_o;
  assign wb_sel_o     = wb_cyc_o ? 4'hF : 4'h0;
  assign wb_adr_o     = wb_cyc_o ? base_q + (aw'(word_q) << 2) : '0;
  assign wb_dat_o     = '0;
  assign wb_we_o      = 1'b0;
  assign wb_cti_o     = 3'b000;
  assign wb_bte_o     = 2'b00;
  assign desc_valid   = (state_q == S_PRESENT);
  assign desc_channel = ch_q;
  assign desc_data    = data_q;
  assign status_reg   = {{(dw-11){1'b0}}, ch_q, 3'b000, sticky_q, (state_q != S_IDLE)};

  logic unused_ok;
  assign unused_ok = ^control_reg;
endmodule

// File: tb/tb_wb_dsp_equation_fetch.sv
// Bench for wb_dsp_equation_fetch: memory-backed Wishbone slave with a
// scripted response queue, transaction-level model of expected addresses and
// descriptors, and a per-cycle compare process.
module tb_wb_dsp_equation_fetch;
  localparam int DW = 32, AW = 32, NCH = 4, DWORDS = 3, NIDX = 2;
  localparam int MRTY = 3, MCHAIN = 2, TMO = 8;

  logic               wb_clk = 1'b0, wb_rst_n = 1'b0;
  logic [AW-1:0]      wb_adr_o;
  logic [DW-1:0]      wb_dat_o;
  logic [3:0]         wb_sel_o;
  logic               wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]         wb_cti_o;
  logic [1:0]         wb_bte_o;
  logic [DW-1:0]      wb_dat_i = '0;
  logic               wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic [NCH-1:0]     begin_equation = '0;
  logic [NCH*AW-1:0]  equation_base = '0;
  logic [DW-1:0]      control_reg = '0;
  logic [DW-1:0]      status_reg;
  logic               desc_valid, desc_ready = 1'b0;
  logic [2:0]         desc_channel;
  logic [DWORDS*DW-1:0] desc_data;

  wb_dsp_equation_fetch #(.dw(DW), .aw(AW), .NUM_CH(NCH), .DESC_WORDS(DWORDS), .NEXT_IDX(NIDX),
    .MAX_RETRY(MRTY), .MAX_CHAIN(MCHAIN), .TIMEOUT_CYCLES(TMO)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i), .begin_equation(begin_equation),
    .equation_base(equation_base), .control_reg(control_reg), .status_reg(status_reg),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_channel(desc_channel),
    .desc_data(desc_data));

  always #5 wb_clk = ~wb_clk;

  int n_chk = 0, n_pass = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_adr[$];
  logic [95:0] exp_dat[$];
  logic [2:0]  exp_ch[$];
  logic [31:0] seen_adr[$];
  logic [2:0]  pres_ch[$];
  int resp_q[$];            // 0 = ack, 1 = rty, 2 = err; empty queue means ack
  bit hang = 1'b0;
  int n_pres = 0, n_rty = 0, rty_phase = 0, beat_rty = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'hDEAD_BEEF;
  endfunction

  // model: first channel served after `last` given a pending mask
  function automatic int rr_next(input logic [NCH-1:0] pend, input int last);
    for (int k = 1; k <= NCH; k++) if (pend[(last + k) % NCH]) return (last + k) % NCH;
    return -1;
  endfunction

  // model: walk the descriptor chain in memory for one start
  task automatic model_start(input int ch, input logic [31:0] base, input bit chain, output bit ovf);
    logic [31:0] b; logic [95:0] d; int n;
    b = base; n = 1; ovf = 1'b0;
    forever begin
      for (int w = 0; w < DWORDS; w++) begin
        exp_adr.push_back(b + 32'(4*w));
        d[w*32 +: 32] = mrd(b + 32'(4*w));
      end
      exp_dat.push_back(d); exp_ch.push_back(3'(ch));
      if (!chain || d[NIDX*32 +: 32] == 32'h0) break;
      if (n >= MCHAIN) begin ovf = 1'b1; break; end
      b = d[NIDX*32 +: 32]; n++;
    end
  endtask

  // slave + per-cycle compare, away from the active edge
  always @(negedge wb_clk) begin
    int r;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0; wb_dat_i = '0;
    if (wb_rst_n) begin
      if (rty_phase == 1) begin
        chk("rty_gap_idle", wb_cyc_o, 0); rty_phase = 2;
      end else if (rty_phase == 2) begin
        chk("rty_reissue", wb_cyc_o, (beat_rty <= MRTY));
        if (beat_rty > MRTY) beat_rty = 0;
        rty_phase = 0;
      end
      if (wb_cyc_o) begin
        chk("stb", wb_stb_o, 1); chk("sel", wb_sel_o, 4'hF); chk("we", wb_we_o, 0);
        chk("beat_expected", exp_adr.size() != 0, 1);
        if (exp_adr.size() != 0) chk("adr", wb_adr_o, exp_adr[0]);
        if (!hang) begin
          r = (resp_q.size() != 0) ? resp_q.pop_front() : 0;
          case (r)
            1: begin wb_rty_i = 1'b1; beat_rty++; n_rty++; rty_phase = 1; end
            2: begin wb_err_i = 1'b1; beat_rty = 0; if (exp_adr.size() != 0) void'(exp_adr.pop_front()); end
            default: begin
              wb_ack_i = 1'b1; wb_dat_i = mrd(wb_adr_o); beat_rty = 0;
              seen_adr.push_back(wb_adr_o);
              if (exp_adr.size() != 0) void'(exp_adr.pop_front());
            end
          endcase
        end
      end else begin
        chk("bus_idle", {wb_stb_o, wb_sel_o, wb_adr_o}, 0);
      end
      if (desc_valid) begin
        chk("desc_expected", exp_dat.size() != 0, 1);
        chk("valid_excl_cyc", wb_cyc_o, 0);
        if (exp_dat.size() != 0) begin
          chk("desc_data", desc_data, exp_dat[0]);
          chk("desc_ch", desc_channel, exp_ch[0]);
        end
        if (desc_ready) begin
          n_pres++; pres_ch.push_back(desc_channel);
          if (exp_dat.size() != 0) begin void'(exp_dat.pop_front()); void'(exp_ch.pop_front()); end
        end
      end
    end
  end

  task automatic tick(); @(posedge wb_clk); #1; endtask
  task automatic pulse_begin(input logic [NCH-1:0] m); begin_equation = m; tick(); begin_equation = '0; endtask
  task automatic pulse_clear(); control_reg[10] = 1'b1; tick(); control_reg[10] = 1'b0; tick(); endtask

  task automatic wait_quiet(input string nm);
    int q, t; q = 0; t = 0;
    while (q < 4 && t < 500) begin tick(); t++; if (!status_reg[0]) q++; else q = 0; end
    chk({nm, "_quiesce"}, (q >= 4), 1);
  endtask

  task automatic wait_cyc_adr(input logic [31:0] a, input string nm);
    int t; t = 0;
    while (!(wb_cyc_o && wb_adr_o == a) && t < 200) begin tick(); t++; end
    chk({nm, "_reach_beat"}, (t < 200), 1);
  endtask

  task automatic drained(input string nm);
    chk({nm, "_drained"}, exp_adr.size() + exp_dat.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ovf; int np0, o1, o2, o3, nwait;
    equation_base = {32'h5000, 32'h2100, 32'h3000, 32'h1000};
    mem[32'h1000] = 32'hAAAA0001; mem[32'h1004] = 32'hBBBB0002; mem[32'h1008] = 32'h0;
    mem[32'h3000] = 32'h31; mem[32'h3004] = 32'h32; mem[32'h3008] = 32'h0;
    mem[32'h5000] = 32'h51; mem[32'h5004] = 32'h52; mem[32'h5008] = 32'h0;
    mem[32'h2100] = 32'h21; mem[32'h2104] = 32'h22; mem[32'h2108] = 32'h2000;
    mem[32'h2000] = 32'h61; mem[32'h2004] = 32'h62; mem[32'h2008] = 32'h0;

    // reset state
    tick(); tick();
    chk("rst_status", status_reg, 0); chk("rst_cyc", {wb_cyc_o, wb_stb_o}, 0);
    chk("rst_bus", {wb_adr_o, wb_sel_o, wb_we_o, wb_cti_o, wb_bte_o, wb_dat_o}, 0);
    chk("rst_desc", {desc_valid, desc_channel, desc_data}, 0);
    wb_rst_n = 1'b1; tick();

    // single descriptor on channel 0, consumer stalls three cycles
    model_start(0, 32'h1000, 1'b0, ovf);
    pulse_begin(4'b0001);
    begin int t; t = 0; while (!desc_valid && t < 50) begin tick(); t++; end end
    chk("t1_valid", desc_valid, 1);
    chk("t1_w0", desc_data[31:0], 32'hAAAA0001); chk("t1_w1", desc_data[63:32], 32'hBBBB0002);
    chk("t1_w2", desc_data[95:64], 32'h0); chk("t1_ch", desc_channel, 0);
    chk("t1_active", status_reg[0], 1);
    tick(); tick(); tick();
    chk("t1_valid_held", {desc_valid, desc_data[31:0]}, {1'b1, 32'hAAAA0001});
    desc_ready = 1'b1; tick(); desc_ready = 1'b0;
    chk("t1_active_drop", {status_reg[0], desc_valid}, 0);
    chk("t1_nadr", seen_adr.size(), 3);
    if (seen_adr.size() == 3) begin
      chk("t1_adr0", seen_adr[0], 32'h1000); chk("t1_adr1", seen_adr[1], 32'h1004);
      chk("t1_adr2", seen_adr[2], 32'h1008);
    end
    drained("t1");
    desc_ready = 1'b1;

    // round-robin: 1 and 3 together, then a late 1 behind pending 3
    o1 = rr_next(4'b1010, 0); o2 = rr_next(4'b1010 & ~(4'b1 << o1) | 4'b0010, o1);
    o3 = rr_next(4'b0010, o2);
    chk("model_rr", {4'(o1), 4'(o2), 4'(o3)}, 12'h131);
    model_start(o1, equation_base[o1*32 +: 32], 1'b0, ovf);
    model_start(o2, equation_base[o2*32 +: 32], 1'b0, ovf);
    model_start(o3, equation_base[o3*32 +: 32], 1'b0, ovf);
    pres_ch.delete();
    pulse_begin(4'b1010);
    wait_cyc_adr(32'h3000, "t2");
    pulse_begin(4'b0010);
    wait_quiet("t2");
    chk("t2_npres", pres_ch.size(), 3);
    if (pres_ch.size() == 3) chk("t2_order", {pres_ch[0], pres_ch[1], pres_ch[2]}, {3'd1, 3'd3, 3'd1});
    drained("t2");

    // chaining: two-link chain, then self-loop hitting the chain cap
    control_reg[9] = 1'b1;
    model_start(2, 32'h2100, 1'b1, ovf);
    chk("model_noovf", ovf, 0);
    np0 = n_pres; pulse_begin(4'b0100); wait_quiet("t3a");
    chk("t3a_npres", n_pres - np0, 2); chk("t3a_ovf", status_reg[3], 0); drained("t3a");
    mem[32'h1008] = 32'h1000;
    model_start(0, 32'h1000, 1'b1, ovf);
    chk("model_ovf", ovf, 1);
    np0 = n_pres; pulse_begin(4'b0001); wait_quiet("t3b");
    chk("t3b_npres", n_pres - np0, 2); chk("t3b_ovf", status_reg[3], 1); drained("t3b");
    pulse_clear(); chk("t3_clear", status_reg[4:1], 0);
    mem[32'h1008] = 32'h0; control_reg[9] = 1'b0;

    // two retries on word 1 recover; four retries fail
    n_rty = 0; resp_q = {0, 1, 1, 0};
    model_start(0, 32'h1000, 1'b0, ovf);
    pulse_begin(4'b0001); wait_quiet("t4a");
    chk("t4a_nrty", n_rty, 2); chk("t4a_buserr", status_reg[1], 0); drained("t4a");
    n_rty = 0; resp_q = {0, 1, 1, 1, 1};
    exp_adr.push_back(32'h1000); exp_adr.push_back(32'h1004);
    np0 = n_pres; pulse_begin(4'b0001); wait_quiet("t4b");
    chk("t4b_nrty", n_rty, 4); chk("t4b_buserr", status_reg[1], 1);
    chk("t4b_nodesc", n_pres - np0, 0); chk("t4b_left", exp_adr.size(), 1);
    exp_adr.delete(); resp_q.delete();
    pulse_clear();

    // err on word 0, clear, then stop during word 1
    resp_q = {2}; exp_adr.push_back(32'h1000);
    np0 = n_pres; pulse_begin(4'b0001); wait_quiet("t5a");
    chk("t5a_status", status_reg[10:0], 11'h002); chk("t5a_nodesc", n_pres - np0, 0); drained("t5a");
    pulse_clear(); chk("t5a_clear", status_reg[1], 0);
    exp_adr.push_back(32'h1000); exp_adr.push_back(32'h1004);
    np0 = n_pres; pulse_begin(4'b0001);
    wait_cyc_adr(32'h1004, "t5b");
    control_reg[8] = 1'b1;
    wait_quiet("t5b"); control_reg[8] = 1'b0;
    chk("t5b_abort", status_reg[2:1], 2'b10); chk("t5b_nodesc", n_pres - np0, 0); drained("t5b");
    pulse_clear();

    // async reset in the middle of WAIT
    hang = 1'b1; exp_adr.push_back(32'h1000);
    pulse_begin(4'b0001); wait_cyc_adr(32'h1000, "t6"); tick();
    chk("t6_inwait", wb_cyc_o, 1);
    wb_rst_n = 1'b0; #1;
    chk("t6_rst_bus", {wb_cyc_o, wb_stb_o, desc_valid}, 0); chk("t6_rst_status", status_reg, 0);
    tick(); exp_adr.delete(); wb_rst_n = 1'b1; tick();

    // unresponsive slave: watchdog when built in, otherwise WAIT holds
    exp_adr.push_back(32'h1000); nwait = 0;
    pulse_begin(4'b0001);
    for (int i = 0; i < 40; i++) begin tick(); if (wb_cyc_o) nwait++; end
`ifdef WB_DSP_EQ_FETCH_TIMEOUT_EN
    chk("t6_tmo_cycles", nwait, TMO); chk("t6_tmo_bit", status_reg[4], 1);
    chk("t6_tmo_idle", wb_cyc_o, 0);
`else
    chk("t6_held", wb_cyc_o, 1); chk("t6_no_tmo", status_reg[4], 0);
    chk("t6_nwait", (nwait > 30), 1);
`endif
    wb_rst_n = 1'b0; tick(); exp_adr.delete(); hang = 1'b0; wb_rst_n = 1'b1; tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wb_dsp_equation_fetch.md
Name: wb_dsp_equation_fetch

Overview:
Parametrised Wishbone-master descriptor fetch engine for the WB DSP equation path. It arbitrates start requests across NUM_CH equation channels and reads a DESC_WORDS-word descriptor from memory with classic single reads. It then presents the whole descriptor to the DSP datapath on a valid/ready handshake and can follow the descriptor's next-pointer chain. It adds retry handling, error reporting, abort and chain-length protection.

Parameters:
dw, 32, Wishbone data width (fixed 32 for byte addressing below)
aw, 32, Wishbone address width
NUM_CH, 4, number of equation channels (1..8)
DESC_WORDS, 3, words per descriptor (3..8)
NEXT_IDX, 2, descriptor word index holding the next-descriptor address
MAX_RETRY, 3, rty responses tolerated per beat before error
MAX_CHAIN, 16, maximum descriptors fetched per start, including the first
TIMEOUT_CYCLES, 256, watchdog limit (used only with WB_DSP_EQ_FETCH_TIMEOUT_EN)

Ports:
wb_clk  in  1  clock
wb_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
wb_adr_o  out  aw  read address
wb_dat_o  out  dw  tied 0
wb_sel_o  out  4  4'hF during a cycle, else 0
wb_we_o  out  1  tied 0
wb_cyc_o  out  1  bus cycle
wb_stb_o  out  1  strobe
wb_cti_o  out  3  tied 3'b000
wb_bte_o  out  2  tied 2'b00
wb_dat_i  in  dw  read data
wb_ack_i  in  1  ack
wb_err_i  in  1  error
wb_rty_i  in  1  retry
begin_equation  in  NUM_CH  one-cycle start pulses, one per channel
equation_base  in  NUM_CH*aw  flat per-channel descriptor base; channel i at [i*aw +: aw]
control_reg  in  dw  [7:0] start per channel (level); [8] stop; [9] chain_en; [10] clear sticky status
status_reg  out  dw  [0] active, [1] bus_error, [2] aborted, [3] chain_overflow, [4] timeout, [10:8] current/last channel, [31:11] 0
desc_valid  out  1  descriptor available
desc_ready  in  1  consumer accepts
desc_channel  out  3  channel that owns the descriptor
desc_data  out  DESC_WORDS*dw  descriptor; word w at [w*dw +: dw]

Behaviour:
- Reset: every output 0, pending 0, state IDLE, sticky bits 0.
- pending[i] is set by begin_equation[i] or by control_reg[i] (for i < NUM_CH). It clears on the cycle channel i is granted. A set and a clear of the same bit in one cycle leave the bit set.
- Arbitration is round-robin. The search starts at last_grant+1 and wraps at NUM_CH. After reset, last_grant = NUM_CH-1, so channel 0 has first priority.
- States: IDLE, FETCH, WAIT, PRESENT, ERROR.
- IDLE: if any pending bit is set, grant it, load base = equation_base[grant], clear word=0, chain=1, retries=0, then go to FETCH.
- FETCH: drive cyc=stb=1, adr=base+4*word, sel=F. Then go to WAIT. The cycle starts on the clock after grant.
- WAIT: hold cyc, stb and adr until a response.
  - ack: latch wb_dat_i into word slot `word`, deassert cyc/stb the same edge, clear retries. If word==DESC_WORDS-1, go to PRESENT; else word+1 and go to FETCH. Minimum latency is 2 cycles per beat.
  - rty: drop cyc/stb for exactly one cycle and retries+1. If retries reaches MAX_RETRY, go to ERROR with bus_error set; else reissue the same beat via FETCH.
  - err: go to ERROR with bus_error set.
  - Priority when several arrive together: err > ack > rty.
- Stop: if control_reg[8] is high in FETCH or WAIT, the current beat completes (ack/err/rty). The engine then returns to IDLE with aborted set and no descriptor presented. Stop in PRESENT takes effect after the handshake and suppresses chaining.
- PRESENT: desc_valid=1 with desc_data/desc_channel stable until desc_ready.
  - On handshake: if chain_en=1 and desc_data word NEXT_IDX != 0 and stop is low, then: if chain < MAX_CHAIN, set base = next, word=0, chain+1, go to FETCH; otherwise set chain_overflow and go to IDLE.
  - In every other case, go to IDLE.
- ERROR: outputs idle for one cycle, then go to IDLE. desc_valid is never asserted for a failed descriptor.
- active = (state != IDLE).
- Sticky bits [4:1] clear only on control_reg[10]. If a set and a clear occur in the same cycle, the set wins.
- Address arithmetic is modulo 2^aw; wrap is allowed.

Optional Feature:
WB_DSP_EQ_FETCH_TIMEOUT_EN:
- Defined: a counter runs in WAIT. If it reaches TIMEOUT_CYCLES without ack/err/rty, drop cyc/stb, set status_reg[4], and go to ERROR.
- Undefined: no counter; WAIT waits indefinitely and status_reg[4] reads 0.

Test Plan:
- Reset, then begin_equation=4'b0001, base0=0x1000, memory 0x1000..0x1008={A,B,0}, zero-wait ack -> three reads at 0x1000/4/8; desc_valid with data {A,B,0}, channel 0; active drops after desc_ready.
- begin_equation=4'b1010 in one cycle -> channel 1 is served first, then channel 3. A later start on channel 1 while channel 3 is pending is served after channel 3 (round-robin).
- chain_en=1, descriptor next=0x2000, descriptor at 0x2000 next=0 -> two descriptors presented back to back from one start; MAX_CHAIN=2 with a self-loop next=0x1000 -> exactly 2 presented, then chain_overflow=1.
- Slave responds rty twice then ack on word 1 -> word 1 reissued twice with one idle cycle between attempts and no error. Four rty responses -> bus_error=1, no desc_valid, returns to IDLE.
- err on word 0 -> status_reg[1]=1; control_reg[10] pulse -> bit cleared. Stop asserted during word 1 WAIT -> beat completes, aborted=1, no descriptor presented.
- wb_rst_n asserted mid-WAIT -> cyc/stb/desc_valid/status go to 0 immediately; with the macro on and TIMEOUT_CYCLES=8 and no slave response, timeout=1 after 8 WAIT cycles.
